bcd_display_scanner: RTL and testbench

Two-digit multiplexed 7-segment display driver sitting directly downstream of the 5-bit binary-to-BCD converter. It captures a packed two-digit BCD value on a load strobe and time-multiplexes the tens and ones digits onto one shared segment bus. A dead-time interval between digits prevents ghosting. It also provides optional leading-zero blanking and flags invalid BCD nibbles.

---
 rtl/bcd_display_scanner.sv | 95 +++++++++
 tb/tb_bcd_display_scanner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed 7-segment scanner: latches a packed BCD pair on load and
// alternates ones/tens on a shared segment bus with a blank dead-time per slot.
module bcd_display_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEAD           = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_in,
  input  logic       load,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic       err
);

  localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD - 1);
  localparam logic [6:0]  SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {BLANK_ONES, SHOW_ONES, BLANK_TENS, SHOW_TENS} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  val, val_nxt;
  logic        err_nxt;
  logic [6:0]  seg_raw;
  logic [1:0]  en_nxt;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  endfunction

  always_comb begin
    val_nxt   = load ? bcd_in : val;
    err_nxt   = load ? ((bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9)) : err;
    cnt_nxt   = (cnt == SLOT_LAST) ? 16'd0 : cnt + 16'd1;
    state_nxt = state;
    case (state)
      BLANK_ONES: if (cnt == DEAD_LAST) state_nxt = SHOW_ONES;
      SHOW_ONES:  if (cnt == SLOT_LAST) state_nxt = BLANK_TENS;
      BLANK_TENS: if (cnt == DEAD_LAST) state_nxt = SHOW_TENS;
      SHOW_TENS:  if (cnt == SLOT_LAST) state_nxt = BLANK_ONES;
      default:    state_nxt = BLANK_ONES;
    endcase
    // Outputs follow next-state and next-val so a load shows up on its own edge.
    seg_raw = 7'h00;
    en_nxt  = 2'b00;
    case (state_nxt)
      SHOW_ONES: begin
        seg_raw = enc(val_nxt[3:0]);
        en_nxt  = 2'b01;
      end
      SHOW_TENS: begin
        if (!(blank_lz && val_nxt[7:4] == 4'd0)) begin
          seg_raw = enc(val_nxt[7:4]);
          en_nxt  = 2'b10;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BLANK_ONES;
      cnt      <= 16'd0;
      val      <= 8'h00;
      err      <= 1'b0;
      seg      <= SEG_OFF;
      digit_en <= 2'b00;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      val      <= val_nxt;
      err      <= err_nxt;
      seg      <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      digit_en <= en_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner at SCAN_DIV=8, DEAD=2; an active-low copy runs in
// parallel on the same stimulus so both polarities are checked every cycle.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bcd_in;
  logic       load;
  logic       blank_lz;
  logic [6:0] seg, seg_al;
  logic [1:0] digit_en, digit_en_al;
  logic       err, err_al;

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(.SCAN_DIV(8), .DEAD(2), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
    .seg(seg), .digit_en(digit_en), .err(err));

  bcd_display_scanner #(.SCAN_DIV(8), .DEAD(2), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
    .seg(seg_al), .digit_en(digit_en_al), .err(err_al));

  typedef struct {
    logic [6:0] seg;
    logic [1:0] en;
    logic       err;
    int         tick;
  } exp_t;

  typedef struct {
    logic [7:0] bcd;
    logic       blz;
    logic [6:0] ones_seg;
    logic [6:0] tens_seg;
    logic [1:0] tens_en;
    logic       err;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[6];

  // what the display should currently show in each slot
  logic [6:0] e_ones, e_tens;
  logic [1:0] e_tens_en;
  logic       e_err;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("seg@%0d", e.tick), int'(seg), int'(e.seg));
      chk($sformatf("en@%0d", e.tick), int'(digit_en), int'(e.en));
      chk($sformatf("err@%0d", e.tick), int'(err), int'(e.err));
      chk($sformatf("seg_al@%0d", e.tick), int'(seg_al), int'(7'h7F ^ e.seg));
      chk($sformatf("en_al@%0d", e.tick), int'(digit_en_al), int'(e.en));
    end
  end

  // one clock edge; expectation comes from the slot position since reset release
  task automatic cyc();
    int p;
    exp_t x;
    @(posedge clk);
    #1;
    t++;
    load = 1'b0;
    p = t % 16;
    x.seg = 7'h00; x.en = 2'b00; x.err = e_err; x.tick = t;
    if (p >= 2 && p <= 7) begin
      x.seg = e_ones; x.en = 2'b01;
    end else if (p >= 10) begin
      x.seg = e_tens; x.en = e_tens_en;
    end
    sb.push_back(x);
  endtask

  task automatic load_at_boundary(input vec_t v);
    while (t % 16 != 15) cyc();
    bcd_in = v.bcd; load = 1'b1; blank_lz = v.blz;
    e_ones = v.ones_seg; e_tens = v.tens_seg; e_tens_en = v.tens_en; e_err = v.err;
    cyc();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg"}, int'(seg), 0);
    chk({tag, "_seg_al"}, int'(seg_al), 'h7F);
    chk({tag, "_en"}, int'(digit_en), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic set_idle_expect();
    e_ones = 7'h3F; e_tens = 7'h3F; e_tens_en = 2'b10; e_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h29, 1'b0, 7'h6F, 7'h5B, 2'b10, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 7'h07, 7'h00, 2'b00, 1'b0};
    vecs[2] = '{8'h07, 1'b0, 7'h07, 7'h3F, 2'b10, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 7'h40, 7'h4F, 2'b10, 1'b1};
    vecs[4] = '{8'h15, 1'b0, 7'h6D, 7'h06, 2'b10, 1'b0};
    vecs[5] = '{8'h88, 1'b0, 7'h7F, 7'h7F, 2'b10, 1'b0};

    rst = 1'b1; load = 1'b0; bcd_in = 8'h00; blank_lz = 1'b0;
    set_idle_expect();
    #3 chk_reset_outputs("rst0");
    @(negedge clk); @(negedge clk);
    rst = 1'b0; t = 0;

    for (int i = 0; i < 32; i++) cyc();

    for (int i = 0; i < 6; i++) begin
      load_at_boundary(vecs[i]);
      for (int k = 0; k < 16; k++) cyc();
    end

    // load mid SHOW_ONES: seg changes on the load edge, slot timing untouched
    load_at_boundary(vecs[0]);
    while (t % 16 != 4) cyc();
    bcd_in = 8'h12; load = 1'b1;
    e_ones = 7'h5B; e_tens = 7'h06;
    cyc();
    for (int k = 0; k < 16; k++) cyc();

    // async reset in SHOW_TENS with err set; a load during reset is discarded
    load_at_boundary(vecs[3]);
    while (t % 16 != 12) cyc();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("rst_async");
    bcd_in = 8'h88; load = 1'b1;
    @(posedge clk);
    #1 chk_reset_outputs("rst_load");
    load = 1'b0;
    @(negedge clk);
    rst = 1'b0; t = 0; blank_lz = 1'b0;
    set_idle_expect();
    for (int i = 0; i < 32; i++) cyc();

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
